param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised synchronous up/down counter. Successor to the fixed 4-bit ripple counter.
- Generalised in width and modulus. Adds direction control, parallel load, synchronous clear, enable, wrap or saturate mode, a terminal-count flag and a sticky overflow flag.
- Used as a general event/timer counter in datapath and control blocks, anywhere a single-clock-domain count is needed.

Parameters:
- WIDTH, 4, counter width in bits (WIDTH >= 2).
- MAX_COUNT, 15, highest count value; count range is 0..MAX_COUNT; must be <= 2^WIDTH-1.
- SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- clr  input  1  synchronous clear.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from q, en, up_dn).
- ovf  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - q=0, ovf=0 immediately.
  - Released synchronously by the integrating block; the counter resumes on the first rising edge with reset=1.
- Per rising edge, priority order clr > load > en:
  - clr=1: q<=0, ovf<=0. load and en are ignored.
  - load=1 (clr=0): q<=load_val if load_val<=MAX_COUNT, else q<=MAX_COUNT (clamped). ovf is unchanged.
  - en=1, up_dn=1:
    - q<MAX_COUNT: q<=q+1.
    - q==MAX_COUNT: q<=0 if SATURATE=0, else q holds. ovf<=1 in both modes.
  - en=1, up_dn=0:
    - q>0: q<=q-1.
    - q==0: q<=MAX_COUNT if SATURATE=0, else q holds at 0. ovf<=1 in both modes.
  - en=0 and no clr/load: q and ovf hold.
- tc = en & ((up_dn & q==MAX_COUNT) | (~up_dn & q==0)).
  - Asserted during the cycle whose next edge crosses the boundary.
  - Zero latency, combinational. Not gated by load/clr.
- ovf stays set until clr=1 or reset=0. A simultaneous boundary event and clr leaves ovf=0, because clr wins.
- Arithmetic is WIDTH bits, unsigned, with no carry out; q never leaves 0..MAX_COUNT.
- Non-power-of-two MAX_COUNT (e.g. 9 for decade counting) is supported.
- up_dn may change on any cycle; the new direction applies at the next edge.
- Reset asserted mid-count: q and ovf clear at once, regardless of clk phase.
- Synthesises to a single WIDTH-bit register plus ovf flop. No ripple clocking; all flops share clk.

Test Plan:
1. Reset and wrap: WIDTH=4, MAX_COUNT=15, SATURATE=0. reset=0 for 2 cycles, then en=1, up_dn=1 for 17 edges.
   - q sequence is 1..15, 0, 1.
   - tc=1 only while q=15.
   - ovf rises on the 16th edge and stays 1.
2. Decade down-count with saturate: MAX_COUNT=9, SATURATE=1. Load 3 (load=1 for one edge), then en=1, up_dn=0 for 5 edges.
   - q sequence is 2, 1, 0, 0, 0.
   - tc=1 while q=0.
   - ovf=1 after the first edge taken at q=0.
3. Priority: with q=5, assert clr=1, load=1 (load_val=7) and en=1 on the same edge.
   - q=0, ovf=0.
   - Next edge with load=1 only: q=7.
   - Load with load_val=12 and MAX_COUNT=9: q=9.
4. Async reset mid-count: MAX_COUNT=15, q=9 counting up, ovf=1. Drop reset between edges.
   - q=0 and ovf=0 before the next clk edge.
   - After release: q=1 on the first edge with en=1.
5. Enable and direction toggle: up_dn alternating every edge with en=1 from q=4.
   - q sequence is 5, 4, 5, 4.
   - With en=0: q holds and tc=0 even when q=0 and up_dn=0.

Source files
------------

// File: rtl/param_updown_counter.sv
// ============================================================================
//  Module      : param_updown_counter
//  Description : Parametrised up/down counter with modulus MAX_COUNT+1,
//                parallel load (clamped), synchronous clear, enable,
//                wrap/saturate boundary mode, combinational terminal-count
//                flag and sticky overflow/underflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
  localparam logic             c_SAT  = (SATURATE != 0);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ovf_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_at_max   = (r_q == c_MAX);
  assign w_at_zero  = (r_q == c_ZERO);
  // A boundary crossing is an enabled step taken from the end of the range
  // in the current direction; this is exactly the terminal-count condition.
  assign w_boundary = en & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

  // Out-of-range load values are clamped so q never leaves 0..MAX_COUNT.
  assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;

  // Next-state selection with priority clr > load > en.
  always_comb begin
    w_q_next   = r_q;
    w_ovf_next = r_ovf;
    if (clr) begin
      w_q_next   = c_ZERO;
      w_ovf_next = 1'b0;
    end else if (load) begin
      w_q_next   = w_load_clamped;
    end else if (en) begin
      if (w_boundary) begin
        w_ovf_next = 1'b1;
        if (!c_SAT) begin
          w_q_next = up_dn ? c_ZERO : c_MAX;
        end
      end else if (up_dn) begin
        w_q_next = r_q + c_ONE;
      end else begin
        w_q_next = r_q - c_ONE;
      end
    end
  end

  // Count and sticky-flag registers; reset clears both asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= c_ZERO;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_ovf <= w_ovf_next;
    end
  end

  assign q   = r_q;
  assign ovf = r_ovf;
  // Terminal count is zero-latency and deliberately not gated by load/clr.
  assign tc  = w_boundary;

endmodule

`default_nettype wire

// File: tb/tb_param_updown_counter.sv
// ============================================================================
//  Module      : tb_param_updown_counter
//  Description : Randomised and directed bench for param_updown_counter.
//                Two instances share stimulus: a 0..15 wrapping counter and
//                a 0..9 saturating decade counter, each tracked by its own
//                modular-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_updown_counter;

  localparam int W = 4;

  logic         clk      = 1'b0;
  logic         reset    = 1'b0;
  logic         en       = 1'b0;
  logic         up_dn    = 1'b0;
  logic         load     = 1'b0;
  logic         clr      = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] q0, q1;
  logic         tc0, tc1, ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  // Reference model state per instance (0: max 15 wrap, 1: max 9 saturate)
  int m_q   [2];
  bit m_ovf [2];
  int m_max [2] = '{15, 9};
  bit m_sat [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(W), .MAX_COUNT(15), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr(clr), .q(q0), .tc(tc0), .ovf(ovf0)
  );

  param_updown_counter #(.WIDTH(W), .MAX_COUNT(9), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr(clr), .q(q1), .tc(tc1), .ovf(ovf1)
  );

  function automatic int dq(int k);
    return (k == 0) ? int'(q0) : int'(q1);
  endfunction

  function automatic bit dtc(int k);
    return (k == 0) ? tc0 : tc1;
  endfunction

  function automatic bit dovf(int k);
    return (k == 0) ? ovf0 : ovf1;
  endfunction

  // Terminal count: an enabled step from the end of the range in the current direction
  function automatic bit exp_tc(int k);
    return en && ((up_dn && m_q[k] == m_max[k]) || (!up_dn && m_q[k] == 0));
  endfunction

  // Model one rising edge from the rules, using modular arithmetic
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      n = m_max[k] + 1;
      if (reset !== 1'b1) begin
        m_q[k] = 0; m_ovf[k] = 1'b0;
      end else if (clr) begin
        m_q[k] = 0; m_ovf[k] = 1'b0;
      end else if (load) begin
        m_q[k] = (int'(load_val) > m_max[k]) ? m_max[k] : int'(load_val);
      end else if (en) begin
        if (up_dn) begin
          if (m_q[k] == m_max[k]) m_ovf[k] = 1'b1;
          if (!(m_sat[k] && m_q[k] == m_max[k])) m_q[k] = (m_q[k] + 1) % n;
        end else begin
          if (m_q[k] == 0) m_ovf[k] = 1'b1;
          if (!(m_sat[k] && m_q[k] == 0)) m_q[k] = (m_q[k] + n - 1) % n;
        end
      end
    end
  endtask

  // Advance one clock; returns at the following falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    m_q = '{0, 0}; m_ovf = '{1'b0, 1'b0};
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dq(k) !== 0 || dovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: q/ovf got %0d/%0b expected 0/0", k, dq(k), dovf(k));
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      checks++;
      if (tc0 !== (i == 15)) begin
        errors++;
        $display("FAIL wrap_tc edge%0d: got %0b expected %0b", i, tc0, (i == 15));
      end
      checks++;
      if (tc1 !== exp_tc(1)) begin
        errors++;
        $display("FAIL wrap_tc dut1 edge%0d: got %0b expected %0b", i, tc1, exp_tc(1));
      end
      step();
      checks++;
      if (int'(q0) !== (i + 1) % 16 || ovf0 !== (i >= 15)) begin
        errors++;
        $display("FAIL wrap dut0 edge%0d: q/ovf got %0d/%0b expected %0d/%0b", i, q0, ovf0, (i + 1) % 16, (i >= 15));
      end
      checks++;
      if (dq(1) !== m_q[1] || dovf(1) !== m_ovf[1]) begin
        errors++;
        $display("FAIL wrap dut1 edge%0d: q/ovf got %0d/%0b expected %0d/%0b", i, dq(1), dovf(1), m_q[1], m_ovf[1]);
      end
    end
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_decade_saturate();
    int exp_seq [5] = '{2, 1, 0, 0, 0};
    load = 1'b1; load_val = W'(3);
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (tc1 !== (i >= 3)) begin
        errors++;
        $display("FAIL decade_tc edge%0d: got %0b expected %0b", i, tc1, (i >= 3));
      end
      step();
      checks++;
      if (int'(q1) !== exp_seq[i] || ovf1 !== (i >= 3)) begin
        errors++;
        $display("FAIL decade dut1 edge%0d: q/ovf got %0d/%0b expected %0d/%0b", i, q1, ovf1, exp_seq[i], (i >= 3));
      end
      checks++;
      if (dq(0) !== m_q[0] || dovf(0) !== m_ovf[0]) begin
        errors++;
        $display("FAIL decade dut0 edge%0d: q/ovf got %0d/%0b expected %0d/%0b", i, dq(0), dovf(0), m_q[0], m_ovf[0]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    int exp12 [2] = '{12, 9};
    load = 1'b1; load_val = W'(5);
    step();
    clr = 1'b1; load = 1'b1; load_val = W'(7); en = 1'b1; up_dn = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dq(k) !== 0 || dovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL priority_clr dut%0d: q/ovf got %0d/%0b expected 0/0", k, dq(k), dovf(k));
      end
    end
    clr = 1'b0; en = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dq(k) !== 7) begin
        errors++;
        $display("FAIL priority_load dut%0d: q got %0d expected 7", k, dq(k));
      end
    end
    load_val = W'(12);
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dq(k) !== exp12[k]) begin
        errors++;
        $display("FAIL load_clamp dut%0d: q got %0d expected %0d", k, dq(k), exp12[k]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = W'(15);
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    en = 1'b0; load = 1'b1; load_val = W'(8);
    step();
    load = 1'b0; en = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dq(k) !== 9 || dovf(k) !== 1'b1) begin
        errors++;
        $display("FAIL pre_reset dut%0d: q/ovf got %0d/%0b expected 9/1", k, dq(k), dovf(k));
      end
    end
    #2 reset = 1'b0;
    m_q = '{0, 0}; m_ovf = '{1'b0, 1'b0};
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dq(k) !== 0 || dovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL async_reset dut%0d: q/ovf got %0d/%0b expected 0/0", k, dq(k), dovf(k));
      end
    end
    step();
    checks++;
    if (q0 !== '0 || q1 !== '0) begin
      errors++;
      $display("FAIL reset_hold: q got %0d/%0d expected 0/0", q0, q1);
    end
    reset = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dq(k) !== 1 || dovf(k) !== 1'b0) begin
        errors++;
        $display("FAIL post_reset dut%0d: q/ovf got %0d/%0b expected 1/0", k, dq(k), dovf(k));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_direction();
    int exp_seq [4] = '{5, 4, 5, 4};
    load = 1'b1; load_val = W'(4);
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dq(k) !== exp_seq[i]) begin
          errors++;
          $display("FAIL direction dut%0d edge%0d: q got %0d expected %0d", k, i, dq(k), exp_seq[i]);
        end
      end
    end
    en = 1'b0; load = 1'b1; load_val = '0;
    step();
    load = 1'b0; up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (tc0 !== 1'b0 || tc1 !== 1'b0) begin
        errors++;
        $display("FAIL disabled_tc: got %0b/%0b expected 0/0", tc0, tc1);
      end
      step();
      checks++;
      if (q0 !== '0 || q1 !== '0) begin
        errors++;
        $display("FAIL disabled_hold: q got %0d/%0d expected 0/0", q0, q1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) < 8);
      up_dn    = ($urandom_range(0, 9) < 6);
      load     = ($urandom_range(0, 15) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      load_val = W'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dtc(k) !== exp_tc(k)) begin
          errors++;
          $display("FAIL random_tc dut%0d iter%0d: got %0b expected %0b", k, i, dtc(k), exp_tc(k));
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 1'b0;
        m_q = '{0, 0}; m_ovf = '{1'b0, 1'b0};
        #1 reset = 1'b1;
      end
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dq(k) !== m_q[k] || dovf(k) !== m_ovf[k]) begin
          errors++;
          $display("FAIL random dut%0d iter%0d: q/ovf got %0d/%0b expected %0d/%0b", k, i, dq(k), dovf(k), m_q[k], m_ovf[k]);
        end
      end
    end
    en = 1'b0; load = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_decade_saturate();
    test_priority();
    test_async_reset();
    test_direction();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
